// File: rtl/branch_ctrl_if.sv
// Execute-stage resolve bus between the pipeline and the branch controller.
// The pipeline (master) presents the EX instruction and the branch-unit
// outcome; the controller (slave) answers with redirect and flush requests.
interface branch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic            ex_pred_taken;
    logic            conti;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport master (
        output ex_valid, ex_is_branch, ex_pc, ex_imm, ex_pred_taken, conti,
        input  redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_pc, ex_imm, ex_pred_taken, conti,
        output redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the EX stage.
// Compares the resolved outcome with the fetch-time prediction, redirects
// fetch and flushes the front of the pipe on a mispredict, trains a 2-bit
// saturating branch history table and keeps saturating perf counters.
module branch_ctrl #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX   = 6,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    branch_ctrl_if.slave     ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << BHT_IDX;
    localparam int SH_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int SH_LOAD = (FLUSH_CYC >= 2) ? FLUSH_CYC - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        SHADOW
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   shadow_q, shadow_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
    logic [1:0]        bht_q [ENTRIES];
    logic [1:0]        bht_d [ENTRIES];

    logic [BHT_IDX-1:0] if_idx;
    logic [BHT_IDX-1:0] ex_idx;
    logic               resolve;
    logic               mispredict;
    logic [XLEN-1:0]    target;
    logic               if_pc_unused;

    assign if_idx       = if_pc[BHT_IDX+1:2];
    assign ex_idx       = ex.ex_pc[BHT_IDX+1:2];
    assign if_pc_unused = ^{if_pc[XLEN-1:BHT_IDX+2], if_pc[1:0], ex.ex_pc[1:0]};

    // Prediction is a straight table read, so a same-cycle update is not yet visible.
    assign pred_taken = bht_q[if_idx][1];

    assign resolve    = (state_q == IDLE) && ex.ex_valid && ex.ex_is_branch;
    assign mispredict = resolve && (ex.conti != ex.ex_pred_taken);
    assign target     = ex.conti ? (ex.ex_pc + ex.ex_imm) : (ex.ex_pc + XLEN'(4));

    assign ex.redirect_valid = redirect_valid_q;
    assign ex.redirect_pc    = redirect_pc_q;
    assign ex.flush          = flush_q;
    assign branch_cnt        = branch_cnt_q;
    assign mispred_cnt       = mispred_cnt_q;

    // Next-state logic: resolve and train in IDLE, then hold flush through the wrong-path window.
    always_comb begin
        state_d          = state_q;
        shadow_d         = shadow_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        bht_d            = bht_q;

        case (state_q)
            IDLE: begin
                if (resolve) begin
                    if (ex.conti && (bht_q[ex_idx] != 2'd3)) begin
                        bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
                    end else if (!ex.conti && (bht_q[ex_idx] != 2'd0)) begin
                        bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
                    end
                    if (branch_cnt_q != '1) begin
                        branch_cnt_d = branch_cnt_q + CNT_W'(1);
                    end
                    if (mispredict) begin
                        if (mispred_cnt_q != '1) begin
                            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                        end
                        state_d          = REDIR;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target;
                        flush_d          = 1'b1;
                    end
                end
            end
            REDIR: begin
                if (FLUSH_CYC == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d  = SHADOW;
                    shadow_d = SH_W'(SH_LOAD);
                    flush_d  = 1'b1;
                end
            end
            SHADOW: begin
                if (shadow_q == '0) begin
                    state_d = IDLE;
                end else begin
                    shadow_d = shadow_q - SH_W'(1);
                    flush_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, registered outputs, counters and history table; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            shadow_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q          <= state_d;
            shadow_q         <= shadow_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
            bht_q            <= bht_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: a default instance and a narrow instance
// (single-cycle flush, 8-entry table, 4-bit counters) share one stimulus stream.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_br = 1'b0;
    logic [31:0] s_pc = '0;
    logic [31:0] s_imm = '0;
    logic        s_pt = 1'b0;
    logic        s_conti = 1'b0;
    logic [31:0] s_if_pc = '0;
    logic        started = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    logic        pred0, pred1;
    logic [15:0] br0, mis0;
    logic [3:0]  br1, mis1;

    branch_ctrl_if #(.XLEN(32)) bus0 ();
    branch_ctrl_if #(.XLEN(32)) bus1 ();

    assign bus0.ex_valid      = s_valid;
    assign bus0.ex_is_branch  = s_br;
    assign bus0.ex_pc         = s_pc;
    assign bus0.ex_imm        = s_imm;
    assign bus0.ex_pred_taken = s_pt;
    assign bus0.conti         = s_conti;
    assign bus1.ex_valid      = s_valid;
    assign bus1.ex_is_branch  = s_br;
    assign bus1.ex_pc         = s_pc;
    assign bus1.ex_imm        = s_imm;
    assign bus1.ex_pred_taken = s_pt;
    assign bus1.conti         = s_conti;

    branch_ctrl #(.XLEN(32), .BHT_IDX(6), .FLUSH_CYC(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .if_pc(s_if_pc), .pred_taken(pred0),
        .ex(bus0), .branch_cnt(br0), .mispred_cnt(mis0)
    );

    branch_ctrl #(.XLEN(32), .BHT_IDX(3), .FLUSH_CYC(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .if_pc(s_if_pc), .pred_taken(pred1),
        .ex(bus1), .branch_cnt(br1), .mispred_cnt(mis1)
    );

    always #5 clk = ~clk;

    // Reference state per instance: history table, counters, remaining flush cycles.
    int          m_fc   [2] = '{2, 1};
    int          m_mask [2] = '{63, 7};
    int          m_cmax [2] = '{65535, 15};
    int          m_bht  [2][64];
    int          m_br   [2];
    int          m_mis  [2];
    int          m_left [2];
    logic        m_rv   [2];
    logic [31:0] m_rpc  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) m_bht[k][i] = 1;
            m_br[k]   = 0;
            m_mis[k]  = 0;
            m_left[k] = 0;
            m_rv[k]   = 1'b0;
            m_rpc[k]  = '0;
        end
    endtask

    task automatic model_step(int k);
        int idx;
        m_rv[k] = 1'b0;
        if (m_left[k] > 0) begin
            m_left[k] = m_left[k] - 1;
        end else if (s_valid && s_br) begin
            idx = int'(s_pc >> 2) & m_mask[k];
            if (s_conti) m_bht[k][idx] = (m_bht[k][idx] < 3) ? m_bht[k][idx] + 1 : 3;
            else         m_bht[k][idx] = (m_bht[k][idx] > 0) ? m_bht[k][idx] - 1 : 0;
            if (m_br[k] < m_cmax[k]) m_br[k] = m_br[k] + 1;
            if (s_conti != s_pt) begin
                if (m_mis[k] < m_cmax[k]) m_mis[k] = m_mis[k] + 1;
                m_left[k] = m_fc[k];
                m_rv[k]   = 1'b1;
                m_rpc[k]  = s_conti ? (s_pc + s_imm) : (s_pc + 32'd4);
            end
        end
    endtask

    function automatic logic model_pred(int k);
        return m_bht[k][int'(s_if_pc >> 2) & m_mask[k]] >= 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle outside reset, both instances must agree with the reference.
    always @(negedge clk) begin
        if (started && !rst) begin
            checkOutput("m0_redirect_valid", 32'(bus0.redirect_valid), 32'(m_rv[0]));
            checkOutput("m0_redirect_pc",    bus0.redirect_pc,         m_rpc[0]);
            checkOutput("m0_flush",          32'(bus0.flush),          32'(m_left[0] > 0));
            checkOutput("m0_branch_cnt",     32'(br0),                 32'(m_br[0]));
            checkOutput("m0_mispred_cnt",    32'(mis0),                32'(m_mis[0]));
            checkOutput("m0_pred_taken",     32'(pred0),               32'(model_pred(0)));
            checkOutput("m1_redirect_valid", 32'(bus1.redirect_valid), 32'(m_rv[1]));
            checkOutput("m1_redirect_pc",    bus1.redirect_pc,         m_rpc[1]);
            checkOutput("m1_flush",          32'(bus1.flush),          32'(m_left[1] > 0));
            checkOutput("m1_branch_cnt",     32'(br1),                 32'(m_br[1]));
            checkOutput("m1_mispred_cnt",    32'(mis1),                32'(m_mis[1]));
            checkOutput("m1_pred_taken",     32'(pred1),               32'(model_pred(1)));
        end
    end

    task automatic applyStimulus(logic v, logic b, logic [31:0] pc, logic [31:0] imm,
                                 logic pt, logic c);
        @(posedge clk);
        #1;
        s_valid = v;
        s_br    = b;
        s_pc    = pc;
        s_imm   = imm;
        s_pt    = pt;
        s_conti = c;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        logic [12:0] bimm;
        int          sel;

        s_if_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;

        @(negedge clk);
        checkOutput("rst_redirect_valid", 32'(bus0.redirect_valid), 32'd0);
        checkOutput("rst_flush",          32'(bus0.flush),          32'd0);
        checkOutput("rst_redirect_pc",    bus0.redirect_pc,         32'd0);
        checkOutput("rst_branch_cnt",     32'(br0),                 32'd0);
        checkOutput("rst_pred_taken",     32'(pred0),               32'd0);

        // Taken mispredict: redirect to 0x140, two flush cycles, entry becomes weakly taken.
        applyStimulus(1, 1, 32'h100, 32'h40, 0, 1);
        idle(1);
        @(negedge clk);
        checkOutput("t1_redirect_valid", 32'(bus0.redirect_valid), 32'd1);
        checkOutput("t1_redirect_pc",    bus0.redirect_pc,         32'h140);
        checkOutput("t1_flush",          32'(bus0.flush),          32'd1);
        checkOutput("t1_mispred_cnt",    32'(mis0),                32'd1);
        checkOutput("t1_branch_cnt",     32'(br0),                 32'd1);
        checkOutput("t1_pred_taken",     32'(pred0),               32'd1);
        idle(1);
        @(negedge clk);
        checkOutput("t1_shadow_rv",    32'(bus0.redirect_valid), 32'd0);
        checkOutput("t1_shadow_flush", 32'(bus0.flush),          32'd1);
        idle(1);
        @(negedge clk);
        checkOutput("t1_end_flush", 32'(bus0.flush),  32'd0);
        checkOutput("t1_hold_pc",   bus0.redirect_pc, 32'h140);

        // Not-taken mispredict falls through to pc+4 with a single pulse.
        applyStimulus(1, 1, 32'h200, 32'h40, 1, 0);
        idle(1);
        @(negedge clk);
        checkOutput("t2_redirect_valid", 32'(bus0.redirect_valid), 32'd1);
        checkOutput("t2_redirect_pc",    bus0.redirect_pc,         32'h204);
        idle(1);
        @(negedge clk);
        checkOutput("t2_single_pulse", 32'(bus0.redirect_valid), 32'd0);
        idle(1);

        // Correct prediction: counted, no redirect.
        applyStimulus(1, 1, 32'h100, 32'h8, 1, 1);
        idle(1);
        @(negedge clk);
        checkOutput("t3_redirect_valid", 32'(bus0.redirect_valid), 32'd0);
        checkOutput("t3_flush",          32'(bus0.flush),          32'd0);
        checkOutput("t3_branch_cnt",     32'(br0),                 32'd3);
        checkOutput("t3_mispred_cnt",    32'(mis0),                32'd2);

        // Wrong-path branches during the flush window are ignored.
        applyStimulus(1, 1, 32'h104, 32'h10, 0, 1);
        applyStimulus(1, 1, 32'h108, 32'h20, 0, 1);
        applyStimulus(1, 1, 32'h108, 32'h20, 0, 1);
        idle(1);
        s_if_pc = 32'h108;
        @(negedge clk);
        checkOutput("t4_redirect_valid", 32'(bus0.redirect_valid), 32'd0);
        checkOutput("t4_flush",          32'(bus0.flush),          32'd0);
        checkOutput("t4_redirect_pc",    bus0.redirect_pc,         32'h114);
        checkOutput("t4_branch_cnt",     32'(br0),                 32'd4);
        checkOutput("t4_mispred_cnt",    32'(mis0),                32'd3);
        checkOutput("t4_bht_untouched",  32'(pred0),               32'd0);

        // Saturate the entry at strongly taken, one not-taken leaves it predicting taken.
        repeat (4) applyStimulus(1, 1, 32'h10C, 32'h4, 1, 1);
        applyStimulus(1, 1, 32'h10C, 32'h4, 0, 0);
        idle(1);
        s_if_pc = 32'h10C;
        @(negedge clk);
        checkOutput("t5_pred_taken",  32'(pred0), 32'd1);
        checkOutput("t5_branch_cnt",  32'(br0),   32'd9);
        checkOutput("t5_mispred_cnt", 32'(mis0),  32'd3);

        // Target wraps past the top of the address space; reset lands mid-flush.
        applyStimulus(1, 1, 32'hFFFF_FFF0, 32'h20, 0, 1);
        idle(1);
        @(negedge clk);
        checkOutput("t6_wrap_pc",      bus0.redirect_pc, 32'h10);
        checkOutput("t6_mispred_cnt",  32'(mis0),        32'd4);
        @(posedge clk);
        #2;
        checkOutput("t6_shadow_flush", 32'(bus0.flush), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_flush",       32'(bus0.flush),          32'd0);
        checkOutput("t6_rst_rv",          32'(bus0.redirect_valid), 32'd0);
        checkOutput("t6_rst_pc",          bus0.redirect_pc,         32'd0);
        checkOutput("t6_rst_branch_cnt",  32'(br0),                 32'd0);
        checkOutput("t6_rst_mispred_cnt", 32'(mis0),                32'd0);
        checkOutput("t6_rst_pred",        32'(pred0),               32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic with frequent index collisions and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            sel     = int'($urandom_range(0, 9));
            s_valid = ($urandom_range(0, 3) != 0);
            s_br    = ($urandom_range(0, 9) < 7);
            if (sel < 5)      s_pc = 32'($urandom_range(0, 127)) << 2;
            else if (sel < 7) s_pc = 32'hFFFF_FF00 | (32'($urandom_range(0, 63)) << 2);
            else              s_pc = $urandom & 32'hFFFF_FFFC;
            bimm    = 13'($urandom);
            s_imm   = (sel == 9) ? $urandom : {{19{bimm[12]}}, bimm[12:1], 1'b0};
            s_pt    = 1'($urandom);
            s_conti = 1'($urandom);
            s_if_pc = ($urandom_range(0, 1) == 0) ? s_pc : (32'($urandom_range(0, 127)) << 2);
            if (n < 2500 && $urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        idle(2);
        @(negedge clk);
        checkOutput("sat_branch_cnt",  32'(br1),  32'hF);
        checkOutput("sat_mispred_cnt", 32'(mis1), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
